store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 97 +++++++++
 tb/tb_store_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - write-back store buffer between the MIPS memory stage and single-port data memory
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        empty,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   count;
    logic [29:0]   adr_mem [DEPTH];
    logic [31:0]   dat_mem [DEPTH];

    logic        full;
    logic        push;
    logic        drain;
    logic        load;
    logic        hit;
    logic [31:0] fwd_data;
    logic [AW-1:0] idx;

    assign full  = (count == (AW+1)'(DEPTH));
    assign push  = memwrite && !full && !reset;
    // memread blocks the drain even when a simultaneous store wins the stage
    assign drain = (count != '0) && !memread && !reset;
    assign load  = memread && !memwrite;
    assign stall = memwrite && full && !reset;
    assign empty = (count == '0);

    // Scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr + AW'(k);
            if (((AW+1)'(k) < count) && (adr_mem[idx] == dataadr[31:2])) begin
                hit      = 1'b1;
                fwd_data = dat_mem[idx];
            end
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_adr  = '0;
        mem_wd   = '0;
        readdata = mem_rd;
        if (drain) begin
            mem_we  = 1'b1;
            mem_adr = {adr_mem[rptr], 2'b00};
            mem_wd  = dat_mem[rptr];
        end else if (load) begin
            mem_adr = dataadr;
        end
        if (load && hit)
            readdata = fwd_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (drain)
                rptr <= rptr + 1'b1;
            case ({push, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            adr_mem[wptr] <= dataadr[31:2];
            dat_mem[wptr] <= writedata;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic        memread;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        empty;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks   = 0;
    int failures = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
        .dataadr(dataadr), .writedata(writedata), .readdata(readdata),
        .stall(stall), .empty(empty), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        memwrite  = w;
        memread   = r;
        dataadr   = a;
        writedata = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_rd = 32'h0;
        drive(1'b1, 1'b0, 32'd4, 32'd3);
        step();
        step();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0h exp=1", empty); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++; if (mem_adr !== 32'd0) begin failures++; $display("FAIL idle_mem_adr got=%0h exp=0", mem_adr); end
        checks++; if (mem_wd !== 32'd0) begin failures++; $display("FAIL idle_mem_wd got=%0h exp=0", mem_wd); end
    endtask

    task automatic test_drain();
        drive(1'b1, 1'b0, 32'd84, 32'd5);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL drain_store_stall got=%0h exp=0", stall); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL drain_store_we got=%0h exp=0", mem_we); end
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0h exp=0", empty); end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL drain_we got=%0h exp=1", mem_we); end
        checks++; if (mem_adr !== 32'd84) begin failures++; $display("FAIL drain_adr got=%0d exp=84", mem_adr); end
        checks++; if (mem_wd !== 32'd5) begin failures++; $display("FAIL drain_wd got=%0d exp=5", mem_wd); end
        step();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_done_empty got=%0h exp=1", empty); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL drain_done_we got=%0h exp=0", mem_we); end
    endtask

    task automatic test_forward();
        drive(1'b1, 1'b0, 32'd80, 32'd7);
        step();
        mem_rd = 32'hdead_beef;
        drive(1'b0, 1'b1, 32'd80, 32'd0);
        checks++; if (readdata !== 32'd7) begin failures++; $display("FAIL fwd_readdata got=%0h exp=7", readdata); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL fwd_we got=%0h exp=0", mem_we); end
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++; if (mem_we !== 1'b1 || mem_adr !== 32'd80 || mem_wd !== 32'd7) begin
            failures++; $display("FAIL fwd_drain got=%0h/%0d/%0d exp=1/80/7", mem_we, mem_adr, mem_wd); end
        step();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fwd_empty got=%0h exp=1", empty); end
    endtask

    task automatic test_youngest();
        drive(1'b1, 1'b1, 32'd100, 32'd1);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL young_st1_we got=%0h exp=0", mem_we); end
        step();
        drive(1'b1, 1'b1, 32'd100, 32'd2);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL young_st2_we got=%0h exp=0", mem_we); end
        step();
        mem_rd = 32'h55;
        drive(1'b0, 1'b1, 32'd100, 32'd0);
        checks++; if (readdata !== 32'd2) begin failures++; $display("FAIL young_readdata got=%0h exp=2", readdata); end
        drive(1'b0, 1'b1, 32'd104, 32'd0);
        checks++; if (readdata !== 32'h55 || mem_adr !== 32'd104) begin
            failures++; $display("FAIL young_miss got=%0h/%0d exp=55/104", readdata, mem_adr); end
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++; if (mem_we !== 1'b1 || mem_adr !== 32'd100 || mem_wd !== 32'd1) begin
            failures++; $display("FAIL young_drain1 got=%0h/%0d/%0d exp=1/100/1", mem_we, mem_adr, mem_wd); end
        step();
        checks++; if (mem_we !== 1'b1 || mem_adr !== 32'd100 || mem_wd !== 32'd2) begin
            failures++; $display("FAIL young_drain2 got=%0h/%0d/%0d exp=1/100/2", mem_we, mem_adr, mem_wd); end
        step();
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL young_empty got=%0h exp=1", empty); end
    endtask

    task automatic test_full();
        logic [31:0] exp_adr [5];
        logic [31:0] exp_wd  [5];
        exp_adr = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h0};
        exp_wd  = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd9};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, exp_adr[i], exp_wd[i]);
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL full_fill_stall%0d got=%0h exp=0", i, stall); end
            step();
        end
        drive(1'b1, 1'b1, 32'd0, 32'd9);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_stall got=%0h exp=1", stall); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL full_held_we got=%0h exp=0", mem_we); end
        step();
        drive(1'b1, 1'b0, 32'd0, 32'd9);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL full_release_stall got=%0h exp=1", stall); end
        checks++; if (mem_we !== 1'b1 || mem_adr !== exp_adr[0] || mem_wd !== exp_wd[0]) begin
            failures++; $display("FAIL full_drain0 got=%0h/%0h/%0d exp=1/%0h/%0d", mem_we, mem_adr, mem_wd, exp_adr[0], exp_wd[0]); end
        step();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL full_accept_stall got=%0h exp=0", stall); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (mem_we !== 1'b1 || mem_adr !== exp_adr[i] || mem_wd !== exp_wd[i]) begin
                failures++; $display("FAIL full_drain%0d got=%0h/%0h/%0d exp=1/%0h/%0d", i, mem_we, mem_adr, mem_wd, exp_adr[i], exp_wd[i]); end
            step();
            drive(1'b0, 1'b0, 32'd0, 32'd0);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%0h exp=1", empty); end
    endtask

    task automatic test_miss();
        mem_rd = 32'h1234;
        drive(1'b0, 1'b1, 32'd60, 32'd0);
        checks++; if (readdata !== 32'h1234) begin failures++; $display("FAIL miss_readdata got=%0h exp=1234", readdata); end
        checks++; if (mem_adr !== 32'd60) begin failures++; $display("FAIL miss_adr got=%0d exp=60", mem_adr); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL miss_we got=%0h exp=0", mem_we); end
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 32'h10, 32'd21);
        step();
        drive(1'b1, 1'b1, 32'h14, 32'd22);
        step();
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL rst_mid_loaded got=%0h exp=0", empty); end
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we_during got=%0h exp=0", mem_we); end
        step();
        reset = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_mid_empty got=%0h exp=1", empty); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we%0d got=%0h exp=0", i, mem_we); end
            step();
        end
        mem_rd = 32'h77;
        drive(1'b0, 1'b1, 32'h10, 32'd0);
        checks++; if (readdata !== 32'h77) begin failures++; $display("FAIL rst_mid_stale got=%0h exp=77", readdata); end
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_drain();
        test_forward();
        test_youngest();
        test_full();
        test_miss();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
